seg_scan_mux: RTL and testbench

//  Parametrised multiplexed seven-segment scan driver, successor to the fixed 8-digit scanner in the game top level.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_hex_decode.sv | 13 +
 rtl/seg_scan_mux.sv | 203 ++++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver.
//   BLANK_GLYPH  all segments off (active low)
//   GLYPH_TBL    active-low {g,f,e,d,c,b,a} glyphs for hex 0..F, indexed by value
//   cnt_w()      counter width helper that never returns 0
package seg_pkg;

    localparam logic [6:0] BLANK_GLYPH = 7'h7F;

    // Element 0 is the rightmost entry, so GLYPH_TBL[h] is the glyph for h.
    localparam logic [15:0][6:0] GLYPH_TBL = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex-to-seven-segment lookup.
//   hex  in  4  digit value 0..F
//   segs out 7  active-low {g,f,e,d,c,b,a}
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] segs
);

    assign segs = GLYPH_TBL[hex];

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment scan driver.
//   CLK, ARST_L          clock, synchronous active-low reset
//   HEXIN, DP_IN, BLANK  per-digit value / decimal point / blank (digit 0 rightmost)
//   LZ_EN                suppress leading zeros
//   FLASH_STB            rising edge starts a flash sequence
//   FLASH_MASK           digits that blink while flashing
//   SEGS_L, DP_L         active-low segment and decimal point bus (registered)
//   SEGEN_L              one-cold digit enable, dark for DEAD_CYC cycles per slot
//   FRAME                one-cycle pulse when the digit index wraps to 0
//   FLASHING             high while a flash sequence is active
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 2500,
    parameter int DEAD_CYC     = 4,
    parameter int FLASH_HALF   = 64,
    parameter int FLASH_CYCLES = 3
) (
    input  logic                    CLK,
    input  logic                    ARST_L,
    input  logic [4*NUM_DIGITS-1:0] HEXIN,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic [NUM_DIGITS-1:0]   BLANK,
    input  logic                    LZ_EN,
    input  logic                    FLASH_STB,
    input  logic [NUM_DIGITS-1:0]   FLASH_MASK,
    output logic [6:0]              SEGS_L,
    output logic                    DP_L,
    output logic [NUM_DIGITS-1:0]   SEGEN_L,
    output logic                    FRAME,
    output logic                    FLASHING
);

    localparam int IDX_W = cnt_w(NUM_DIGITS);
    localparam int PRE_W = cnt_w(SCAN_DIV);
    localparam int FC_W  = cnt_w(FLASH_HALF);
    localparam int HC_W  = cnt_w(2 * FLASH_CYCLES + 1);

    // scan state
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    run_q, run_d;
    logic                    frame_q, frame_d;
    logic                    slot_en, wrap;

    // frame snapshot
    logic [4*NUM_DIGITS-1:0] hex_s_q, hex_s_d;
    logic [NUM_DIGITS-1:0]   dp_s_q, dp_s_d;
    logic [NUM_DIGITS-1:0]   blank_s_q, blank_s_d;
    logic [NUM_DIGITS-1:0]   mask_s_q, mask_s_d;

    // flash state
    logic                    stb_q, stb_d;
    logic                    flashing_q, flashing_d;
    logic                    phase_off_q, phase_off_d;
    logic [FC_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic [HC_W-1:0]         half_cnt_q, half_cnt_d;
    logic                    flash_start;

    // output registers
    logic [6:0]              segs_q, segs_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   segen_q, segen_d;

    // display datapath
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_above;
    logic [3:0]              cur_hex;
    logic [6:0]              glyph;
    logic                    dark;

    // ---------------- scan counters and frame snapshot ----------------
    always_comb begin
        slot_en   = (pre_q == PRE_W'(SCAN_DIV - 1));
        wrap      = slot_en && (idx_q == IDX_W'(NUM_DIGITS - 1));
        pre_d     = slot_en ? '0 : pre_q + 1'b1;
        idx_d     = idx_q;
        if (slot_en)
            idx_d = wrap ? '0 : idx_q + 1'b1;
        // Display stays dark until the first slot boundary after reset.
        run_d     = run_q | slot_en;
        frame_d   = wrap;
        hex_s_d   = hex_s_q;
        dp_s_d    = dp_s_q;
        blank_s_d = blank_s_q;
        mask_s_d  = mask_s_q;
        if (wrap) begin
            hex_s_d   = HEXIN;
            dp_s_d    = DP_IN;
            blank_s_d = BLANK;
            mask_s_d  = FLASH_MASK;
        end
    end

    // ---------------- flash sequencer ----------------
    always_comb begin
        stb_d       = FLASH_STB;
        flash_start = FLASH_STB & ~stb_q;
        flashing_d  = flashing_q;
        phase_off_d = phase_off_q;
        frame_cnt_d = frame_cnt_q;
        half_cnt_d  = half_cnt_q;
        if (flash_start) begin
            // A new start always restarts the sequence, even on its last frame.
            flashing_d  = 1'b1;
            phase_off_d = 1'b1;
            frame_cnt_d = '0;
            half_cnt_d  = HC_W'(2 * FLASH_CYCLES);
        end else if (flashing_q && frame_q) begin
            if (frame_cnt_q == FC_W'(FLASH_HALF - 1)) begin
                frame_cnt_d = '0;
                phase_off_d = ~phase_off_q;
                half_cnt_d  = half_cnt_q - 1'b1;
                if (half_cnt_q == HC_W'(1)) begin
                    flashing_d  = 1'b0;
                    phase_off_d = 1'b0;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- leading-zero mask ----------------
    // Walk down from the top digit; a digit is suppressible while every
    // digit at or above it is zero. Digit 0 is always shown.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (hex_s_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_above;
        end
    end

    // ---------------- digit mux and output stage ----------------
    assign cur_hex = hex_s_q[{idx_q, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .hex  (cur_hex),
        .segs (glyph)
    );

    always_comb begin
        dark = ~run_q
             | blank_s_q[idx_q]
             | (LZ_EN & lz_mask[idx_q])
             | (flashing_q & phase_off_q & mask_s_q[idx_q]);
        segs_d  = dark ? BLANK_GLYPH : glyph;
        dp_d    = dark ? 1'b1 : ~dp_s_q[idx_q];
        // Enable is registered from the same pre/idx as the segments, so the
        // stale first cycle after an idx change always falls in dead time.
        segen_d = '1;
        if (run_q && (pre_q >= PRE_W'(DEAD_CYC)))
            segen_d[idx_q] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!ARST_L) begin
            pre_q       <= '0;
            idx_q       <= '0;
            run_q       <= 1'b0;
            frame_q     <= 1'b0;
            hex_s_q     <= '0;
            dp_s_q      <= '0;
            blank_s_q   <= '0;
            mask_s_q    <= '0;
            stb_q       <= 1'b0;
            flashing_q  <= 1'b0;
            phase_off_q <= 1'b0;
            frame_cnt_q <= '0;
            half_cnt_q  <= '0;
            segs_q      <= BLANK_GLYPH;
            dp_q        <= 1'b1;
            segen_q     <= '1;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            frame_q     <= frame_d;
            hex_s_q     <= hex_s_d;
            dp_s_q      <= dp_s_d;
            blank_s_q   <= blank_s_d;
            mask_s_q    <= mask_s_d;
            stb_q       <= stb_d;
            flashing_q  <= flashing_d;
            phase_off_q <= phase_off_d;
            frame_cnt_q <= frame_cnt_d;
            half_cnt_q  <= half_cnt_d;
            segs_q      <= segs_d;
            dp_q        <= dp_d;
            segen_q     <= segen_d;
        end
    end

    assign SEGS_L   = segs_q;
    assign DP_L     = dp_q;
    assign SEGEN_L  = segen_q;
    assign FRAME    = frame_q;
    assign FLASHING = flashing_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench for seg_scan_mux (4 digits, 4-cycle slots).
// Expected per-digit glyphs are queued when a frame's data is known and
// compared at the first lit cycle of each digit slot.
module tb_seg_scan_mux;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        arst_l;
    logic [15:0] hexin;
    logic [3:0]  dp_in, blank, flash_mask;
    logic        lz_en, flash_stb;
    logic [6:0]  segs_l;
    logic        dp_l;
    logic [3:0]  segen_l;
    logic        frame, flashing;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS(ND), .SCAN_DIV(4), .DEAD_CYC(1), .FLASH_HALF(2), .FLASH_CYCLES(1)
    ) dut (
        .CLK(clk), .ARST_L(arst_l), .HEXIN(hexin), .DP_IN(dp_in), .BLANK(blank),
        .LZ_EN(lz_en), .FLASH_STB(flash_stb), .FLASH_MASK(flash_mask),
        .SEGS_L(segs_l), .DP_L(dp_l), .SEGEN_L(segen_l), .FRAME(frame), .FLASHING(flashing)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [1:0] idx;
        logic [6:0] segs;
        logic       dp;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] segen_prev = 4'hF;

    function automatic int dec_idx(input logic [3:0] s);
        int r = -1;
        for (int i = 0; i < ND; i++) if (!s[i]) r = i;
        return r;
    endfunction

    // Queue the four digits of one frame.
    task automatic push_frame(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl,
                              input logic lz, input logic [3:0] fdark);
        int   top = 0;
        exp_t e;
        logic d;
        for (int i = 0; i < ND; i++) if (h[4*i +: 4] != 4'h0) top = i;
        for (int i = 0; i < ND; i++) begin
            d      = bl[i] | (lz && i > top) | fdark[i];
            e.idx  = 2'(i);
            e.segs = d ? 7'h7F : gl[h[4*i +: 4]];
            e.dp   = d ? 1'b1 : ~dp[i];
            sb.push_back(e);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame !== 1'b1 && n < 40);
        if (n >= 40) chk("frame_timeout", {31'd0, frame}, 32'd1);
    endtask

    // Monitor: compare at the first enabled cycle of each slot.
    always @(negedge clk) begin
        if (arst_l === 1'b1 && segen_l != 4'hF && segen_prev == 4'hF && sb.size() > 0) begin
            chk("slot_idx", dec_idx(segen_l), {30'd0, sb[0].idx});
            chk($sformatf("segs_d%0d", sb[0].idx), {25'd0, segs_l}, {25'd0, sb[0].segs});
            chk($sformatf("dp_d%0d", sb[0].idx), {31'd0, dp_l}, {31'd0, sb[0].dp});
            sb.delete(0);
        end
        segen_prev <= segen_l;
    end

    logic [3:0] one = 4'b0001;

    initial begin
        arst_l = 1'b0; hexin = 16'h1230; dp_in = '0; blank = '0; flash_mask = '0;
        lz_en = 1'b0; flash_stb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_segs", {25'd0, segs_l}, 32'h7F);
        chk("rst_dp", {31'd0, dp_l}, 32'd1);
        chk("rst_segen", {28'd0, segen_l}, 32'hF);
        chk("rst_frame", {31'd0, frame}, 32'd0);
        chk("rst_flashing", {31'd0, flashing}, 32'd0);
        arst_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("pre_slot_segen", {28'd0, segen_l}, 32'hF);
            chk("pre_slot_segs", {25'd0, segs_l}, 32'h7F);
        end

        // First frame: 1230 with LZ off; check the enable pattern and FRAME period.
        wait_frame();
        push_frame(16'h1230, 4'h0, 4'h0, 1'b0, 4'h0);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("segen_k%0d", k), {28'd0, segen_l},
                {28'd0, ((k - 1) % 4 == 0) ? 4'hF : ~(one << ((k - 1) / 4))});
            chk("frame_low", {31'd0, frame}, 32'd0);
        end
        @(negedge clk);
        chk("frame_period", {31'd0, frame}, 32'd1);

        // Leading-zero suppression.
        hexin = 16'h0050; lz_en = 1'b1;
        wait_frame();
        push_frame(16'h0050, 4'h0, 4'h0, 1'b1, 4'h0);
        // Change data mid-frame: this frame must still show 0050.
        repeat (6) @(negedge clk);
        hexin = 16'h8F7E;
        wait_frame();
        push_frame(16'h8F7E, 4'h0, 4'h0, 1'b1, 4'h0);

        // Blank and decimal point.
        hexin = 16'h1230; lz_en = 1'b0; blank = 4'b0010; dp_in = 4'b0001;
        wait_frame();
        push_frame(16'h1230, 4'b0001, 4'b0010, 1'b0, 4'h0);

        // Flash run 1: strobe held 10 cycles, started after digit 0's slot.
        hexin = 16'h4321; blank = '0; dp_in = '0; flash_mask = 4'b0001;
        wait_frame();
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'h0);
        repeat (4) @(negedge clk);
        chk("flash_idle", {31'd0, flashing}, 32'd0);
        flash_stb = 1'b1;
        repeat (10) @(negedge clk);
        chk("flash_on", {31'd0, flashing}, 32'd1);
        flash_stb = 1'b0;
        wait_frame();
        chk("flash_f2", {31'd0, flashing}, 32'd1);
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'b0001);
        wait_frame();
        chk("flash_f3", {31'd0, flashing}, 32'd1);
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'h0);
        wait_frame();
        chk("flash_f4", {31'd0, flashing}, 32'd1);
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'h0);
        wait_frame();
        chk("flash_last", {31'd0, flashing}, 32'd1);
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'h0);
        @(negedge clk);
        chk("flash_done", {31'd0, flashing}, 32'd0);

        // Flash run 2 with a retrigger in its third frame, then reset mid-flash.
        repeat (3) @(negedge clk);
        flash_stb = 1'b1;
        repeat (2) @(negedge clk);
        flash_stb = 1'b0;
        wait_frame();
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'b0001);
        wait_frame();
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'h0);
        repeat (4) @(negedge clk);
        flash_stb = 1'b1;
        repeat (2) @(negedge clk);
        flash_stb = 1'b0;
        wait_frame();
        chk("retrig_f1", {31'd0, flashing}, 32'd1);
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'b0001);
        wait_frame();
        chk("retrig_f2", {31'd0, flashing}, 32'd1);
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'h0);
        wait_frame();
        chk("retrig_f3", {31'd0, flashing}, 32'd1);
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'h0);
        wait_frame();
        chk("retrig_f4", {31'd0, flashing}, 32'd1);
        arst_l = 1'b0;
        @(negedge clk);
        chk("mid_rst_flashing", {31'd0, flashing}, 32'd0);
        chk("mid_rst_segs", {25'd0, segs_l}, 32'h7F);
        chk("mid_rst_dp", {31'd0, dp_l}, 32'd1);
        chk("mid_rst_segen", {28'd0, segen_l}, 32'hF);
        chk("mid_rst_frame", {31'd0, frame}, 32'd0);
        arst_l = 1'b1;
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
